// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   ID-stage hazard unit. It keeps one countdown counter per architectural
//   register and sets it when a load issues. An instruction in ID whose used
//   sources are still counting down is held with a bubble until the load
//   data is available. A HALT opcode latches a sticky halt, and only reset
//   releases it. A taken-branch flush overrides everything. Stalled cycles are
//   counted with a saturating counter.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   id_valid        IF/ID holds a valid instruction
//   opcode          opcode of the ID instruction
//   id_rs, id_rt    source specifiers
//   id_uses_rs/rt   instruction actually reads rs / rt
//   id_is_load      ID instruction is a memory read
//   id_rd           load destination register
//   flush           squash the ID instruction
//   stall           bubble into ID/EX (combinational)
//   pc_write        = ~stall
//   if_id_write     = ~stall
//   halted          sticky halt state
//   stall_cycles    saturating count of stalled cycles
module hazard_scoreboard #(
    parameter int unsigned     REG_W    = 4,
    parameter int unsigned     OP_W     = 4,
    parameter logic [OP_W-1:0] HALT_OP  = 4'b1111,
    parameter int unsigned     LOAD_LAT = 1,
    parameter bit              ZERO_REG = 1'b1,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [OP_W-1:0]  opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_load,
    input  logic [REG_W-1:0] id_rd,
    input  logic             flush,
    output logic             stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned   NUM_REGS = 2 ** REG_W;
    localparam int unsigned   CW       = $clog2(LOAD_LAT + 1);
    localparam logic [CW-1:0] LAT_V    = CW'(LOAD_LAT);

    logic [CW-1:0]    r_cnt [NUM_REGS];
    logic             r_halted;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_busy_rs;
    logic w_busy_rt;
    logic w_halt_dec;
    logic w_stall;
    logic w_issue;
    logic w_load_set;

    // Register 0 is excluded from hazard tracking when it is hardwired zero.
    assign w_busy_rs  = id_uses_rs && (r_cnt[id_rs] != '0) && !(ZERO_REG && (id_rs == '0));
    assign w_busy_rt  = id_uses_rt && (r_cnt[id_rt] != '0) && !(ZERO_REG && (id_rt == '0));
    assign w_halt_dec = id_valid && (opcode == HALT_OP);

    // Flush outranks the halt state, which outranks data hazards.
    always_comb begin
        w_stall = 1'b0;
        if (flush)
            w_stall = 1'b0;
        else if (r_halted || w_halt_dec)
            w_stall = 1'b1;
        else
            w_stall = id_valid && (w_busy_rs || w_busy_rt);
    end

    assign w_issue    = id_valid && !flush && !w_stall;
    assign w_load_set = w_issue && id_is_load && !(ZERO_REG && (id_rd == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                r_cnt[i] <= '0;
            r_halted       <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            // A newly issued load reloads its counter and takes precedence
            // over that counter's decrement (WAW reload).
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (w_load_set && (id_rd == REG_W'(i)))
                    r_cnt[i] <= LAT_V;
                else if (r_cnt[i] != '0)
                    r_cnt[i] <= r_cnt[i] - 1'b1;
            end
            if (w_halt_dec && !flush && !r_halted)
                r_halted <= 1'b1;
            if (w_stall && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall        = w_stall;
    assign pc_write     = !w_stall;
    assign if_id_write  = !w_stall;
    assign halted       = r_halted;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard. Two instances share one stimulus stream:
// u_l1 (LOAD_LAT=1, CNT_W=16) and u_l3 (LOAD_LAT=3, CNT_W=4). The reference
// model stores, per register, the first cycle number in which a reader may
// proceed, and compares it with the current cycle number.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [3:0] opcode = '0;
    logic [3:0] id_rs = '0;
    logic [3:0] id_rt = '0;
    logic       id_uses_rs = 1'b0;
    logic       id_uses_rt = 1'b0;
    logic       id_is_load = 1'b0;
    logic [3:0] id_rd = '0;
    logic       flush = 1'b0;

    logic        stall_a, pcw_a, ifw_a, halted_a;
    logic [15:0] sc_a;
    logic        stall_b, pcw_b, ifw_b, halted_b;
    logic [3:0]  sc_b;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_W(4), .OP_W(4), .HALT_OP(4'b1111), .LOAD_LAT(1),
                        .ZERO_REG(1'b1), .CNT_W(16)) u_l1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_load(id_is_load), .id_rd(id_rd), .flush(flush),
        .stall(stall_a), .pc_write(pcw_a), .if_id_write(ifw_a),
        .halted(halted_a), .stall_cycles(sc_a));

    hazard_scoreboard #(.REG_W(4), .OP_W(4), .HALT_OP(4'b1111), .LOAD_LAT(3),
                        .ZERO_REG(1'b1), .CNT_W(4)) u_l3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_load(id_is_load), .id_rd(id_rd), .flush(flush),
        .stall(stall_b), .pc_write(pcw_b), .if_id_write(ifw_b),
        .halted(halted_b), .stall_cycles(sc_b));

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = u_l1, index 1 = u_l3.
    int cyc;
    int lat [2] = '{1, 3};
    int smax[2] = '{65535, 15};
    int ready[2][16];
    bit m_halted[2];
    int m_sc[2];
    bit m_stall[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 16; r++) ready[k][r] = 0;
            m_halted[k] = 1'b0;
            m_sc[k]     = 0;
        end
    endtask

    function automatic bit reg_busy(input int k, input int r, input bit used);
        return used && (r != 0) && (cyc < ready[k][r]);
    endfunction

    task automatic model_eval();
        bit hd;
        hd = id_valid && (opcode == 4'hF);
        for (int k = 0; k < 2; k++) begin
            if (flush) m_stall[k] = 1'b0;
            else if (m_halted[k] || hd) m_stall[k] = 1'b1;
            else m_stall[k] = id_valid && (reg_busy(k, int'(id_rs), id_uses_rs) ||
                                           reg_busy(k, int'(id_rt), id_uses_rt));
        end
    endtask

    task automatic model_edge();
        bit hd;
        hd = id_valid && (opcode == 4'hF);
        for (int k = 0; k < 2; k++) begin
            if (m_stall[k]) m_sc[k] = (m_sc[k] < smax[k]) ? m_sc[k] + 1 : smax[k];
            if (hd && !flush) m_halted[k] = 1'b1;
            if (id_valid && !flush && !m_stall[k] && id_is_load && id_rd != 4'd0)
                ready[k][id_rd] = cyc + 1 + lat[k];
        end
        cyc++;
    endtask

    task automatic check_outputs();
        chk("l1.stall",        32'(stall_a),  32'(m_stall[0]));
        chk("l1.pc_write",     32'(pcw_a),    32'(!m_stall[0]));
        chk("l1.if_id_write",  32'(ifw_a),    32'(!m_stall[0]));
        chk("l1.halted",       32'(halted_a), 32'(m_halted[0]));
        chk("l1.stall_cycles", 32'(sc_a),     32'(m_sc[0]));
        chk("l3.stall",        32'(stall_b),  32'(m_stall[1]));
        chk("l3.pc_write",     32'(pcw_b),    32'(!m_stall[1]));
        chk("l3.if_id_write",  32'(ifw_b),    32'(!m_stall[1]));
        chk("l3.halted",       32'(halted_b), 32'(m_halted[1]));
        chk("l3.stall_cycles", 32'(sc_b),     32'(m_sc[1]));
    endtask

    // One clock cycle: drive ID inputs, check mid-cycle, take the edge.
    task automatic step(input bit v, input logic [3:0] op, input logic [3:0] rs,
                        input logic [3:0] rt, input bit urs, input bit urt,
                        input bit ld, input logic [3:0] rd, input bit fl);
        id_valid = v; opcode = op; id_rs = rs; id_rt = rt;
        id_uses_rs = urs; id_uses_rt = urt; id_is_load = ld; id_rd = rd; flush = fl;
        #1;
        model_eval();
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Reset pulse between clock edges with the current inputs held.
    task automatic reset_mid();
        rst = 1'b1;
        #1;
        model_reset();
        model_eval();
        check_outputs();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;

        // Reset state with an idle ID stage.
        step(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0);

        // Load-use on r3: one bubble at latency 1, three at latency 3.
        step(1, 4'h1, 4'h0, 4'h0, 0, 0, 1, 4'h3, 0);
        repeat (4) step(1, 4'h2, 4'h3, 4'h0, 1, 0, 0, 4'h0, 0);

        // Independent reader right behind a load.
        step(1, 4'h1, 4'h0, 4'h0, 0, 0, 1, 4'h3, 0);
        step(1, 4'h2, 4'h5, 4'h6, 1, 1, 0, 4'h0, 0);
        repeat (3) step(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0);

        // rt matches the load but is not read.
        step(1, 4'h1, 4'h0, 4'h0, 0, 0, 1, 4'h4, 0);
        step(1, 4'h2, 4'h1, 4'h4, 1, 0, 0, 4'h0, 0);

        // Load to r0 followed by an r0 reader.
        step(1, 4'h1, 4'h0, 4'h0, 0, 0, 1, 4'h0, 0);
        step(1, 4'h2, 4'h0, 4'h0, 1, 1, 0, 4'h0, 0);
        repeat (3) step(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0);

        // Flush beats HALT and a load, then an r2 reader proceeds.
        step(1, 4'hF, 4'h0, 4'h0, 0, 0, 0, 4'h0, 1);
        step(1, 4'h1, 4'h0, 4'h0, 0, 0, 1, 4'h2, 1);
        step(1, 4'h2, 4'h2, 4'h0, 1, 0, 0, 4'h0, 0);

        // Asynchronous reset in the middle of a countdown.
        step(1, 4'h1, 4'h0, 4'h0, 0, 0, 1, 4'h3, 0);
        step(1, 4'h2, 4'h3, 4'h0, 1, 0, 0, 4'h0, 0);
        step(1, 4'h2, 4'h3, 4'h0, 1, 0, 0, 4'h0, 0);
        reset_mid();
        step(1, 4'h2, 4'h3, 4'h0, 1, 0, 0, 4'h0, 0);

        // HALT held for a long time, with saturation of the 4-bit counter.
        step(1, 4'hF, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0);
        for (int i = 0; i < 20; i++)
            step(1, 4'($urandom_range(0, 14)), 4'($urandom), 4'($urandom), 0, 0, 0, 4'h0, 0);
        reset_mid();
        step(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0);

        // Randomized traffic with occasional HALT, flush and reset.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) reset_mid();
            step($urandom_range(0, 7) != 0,
                 ($urandom_range(0, 31) == 0) ? 4'hF : 4'($urandom_range(0, 14)),
                 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                 4'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
